// File: rtl/fullconnect_pkg.sv
// Shared types for the fully-connected engine burst read master:
// controller state encoding and the response tag carried through the tag FIFO.
package fullconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Wide enough for the largest weight channel count (8 channels).
  localparam int unsigned TAG_CH_W = 3;

  // Tag pushed for every accepted read; popped in order by readdatavalid.
  typedef struct packed {
    logic                is_data;
    logic [TAG_CH_W-1:0] ch;
  } tag_t;

endpackage

// File: rtl/fullconnect_tag_fifo.sv
// In-order tag FIFO for outstanding Avalon reads. Depth is a power of two;
// push and pop in the same cycle are allowed even when full.
module fullconnect_tag_fifo
  import fullconnect_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic push_i,
  input  tag_t din_i,
  input  logic pop_i,
  output tag_t dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  tag_t             mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Tag storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

endmodule

// File: rtl/fullconnect_burst_read_master.sv
// Avalon-MM pipelined read master for the fully-connected engine. For each
// vector index it reads one data word then NUM_WGT weight words, keeps up to
// MAX_PENDING reads in flight and forwards tagged responses one cycle later.
// Optional build macro FULLCONNECT_RDM_STALLCNT_EN adds a 32-bit stall counter.
module fullconnect_burst_read_master
  import fullconnect_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH  = 64,
  parameter  int unsigned DATA_WIDTH  = 512,
  parameter  int unsigned LEN_WIDTH   = 9,
  parameter  int unsigned NUM_WGT     = 4,
  parameter  int unsigned MAX_PENDING = 8,
  localparam int unsigned CH_W        = (NUM_WGT > 1) ? $clog2(NUM_WGT) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    Start_i,
  input  logic [LEN_WIDTH-1:0]    Len_i,
  input  logic [ADDR_WIDTH-1:0]   DataBase_i,
  input  logic [ADDR_WIDTH-1:0]   WgtBase_i,
  input  logic [ADDR_WIDTH-1:0]   WgtStride_i,
  output logic [ADDR_WIDTH-1:0]   AvalonAddr_o,
  output logic                    AvalonRead_o,
  output logic                    AvalonLock_o,
  output logic [DATA_WIDTH/8-1:0] AvalonByteEnable_o,
  input  logic                    AvalonWaitReq_i,
  input  logic [DATA_WIDTH-1:0]   AvalonReadData_i,
  input  logic                    AvalonReadDataValid_i,
  output logic                    DataValid_o,
  output logic                    WgtValid_o,
  output logic [CH_W-1:0]         WgtCh_o,
  output logic [DATA_WIDTH-1:0]   Rd_o,
  output logic                    Busy_o,
`ifdef FULLCONNECT_RDM_STALLCNT_EN
  output logic [31:0]             StallCnt_o,
`endif
  output logic                    Done_o
);

  localparam int unsigned SLOT_W = $clog2(NUM_WGT + 1);
  localparam int unsigned PEND_W = $clog2(MAX_PENDING) + 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_WGT);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    idx_q, idx_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [ADDR_WIDTH-1:0]   data_base_q, data_base_d;
  logic [ADDR_WIDTH-1:0]   wgt_base_q, wgt_base_d;
  logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]   chan_base_q, chan_base_d;  // WgtBase + c*WgtStride for the current weight slot
  logic [PEND_W-1:0]       pending_q, pending_d;

  logic                    rd_en;
  logic                    accept;
  logic                    pop;
  tag_t                    push_tag;
  tag_t                    pop_tag;
  logic                    fifo_full;
  logic                    fifo_empty;

  logic                    data_valid_q;
  logic                    wgt_valid_q;
  logic [CH_W-1:0]         wgt_ch_q;
  logic [DATA_WIDTH-1:0]   rd_q;

  assign rd_en  = (state_q == ST_ISSUE) && (pending_q < PEND_MAX);
  assign accept = rd_en && !AvalonWaitReq_i;
  assign pop    = AvalonReadDataValid_i && !fifo_empty;

  assign push_tag.is_data = (slot_q == '0);
  assign push_tag.ch      = (slot_q == '0) ? '0 : TAG_CH_W'(slot_q - SLOT_W'(1));

  fullconnect_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (accept),
    .din_i   (push_tag),
    .pop_i   (pop),
    .dout_o  (pop_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, slot/index sequencing and outstanding-read accounting.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    slot_d      = slot_q;
    data_base_d = data_base_q;
    wgt_base_d  = wgt_base_q;
    stride_d    = stride_q;
    chan_base_d = chan_base_q;
    pending_d   = pending_q + PEND_W'(accept) - PEND_W'(pop);

    unique case (state_q)
      ST_IDLE: begin
        if (Start_i) begin
          if (Len_i != '0) begin
            state_d     = ST_ISSUE;
            len_d       = Len_i;
            data_base_d = DataBase_i;
            wgt_base_d  = WgtBase_i;
            stride_d    = WgtStride_i;
            chan_base_d = WgtBase_i;
            idx_d       = '0;
            slot_d      = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          if (slot_q == LAST_SLOT) begin
            slot_d      = '0;
            idx_d       = idx_q + LEN_WIDTH'(1);
            chan_base_d = wgt_base_q;
            if (idx_q == len_q - LEN_WIDTH'(1)) state_d = ST_DRAIN;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
            if (slot_q != '0) chan_base_d = chan_base_q + stride_q;
          end
        end
      end
      ST_DRAIN: begin
        // Nothing outstanding and nothing about to enter the output register.
        if (pending_q == '0 && !pop) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and address-generation registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      slot_q      <= '0;
      data_base_q <= '0;
      wgt_base_q  <= '0;
      stride_q    <= '0;
      chan_base_q <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      slot_q      <= slot_d;
      data_base_q <= data_base_d;
      wgt_base_q  <= wgt_base_d;
      stride_q    <= stride_d;
      chan_base_q <= chan_base_d;
      pending_q   <= pending_d;
    end
  end

  // Response output register: one cycle after readdatavalid, tagged by the popped entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_valid_q <= 1'b0;
      wgt_valid_q  <= 1'b0;
      wgt_ch_q     <= '0;
      rd_q         <= '0;
    end else begin
      data_valid_q <= pop && pop_tag.is_data;
      wgt_valid_q  <= pop && !pop_tag.is_data;
      if (pop) begin
        rd_q <= AvalonReadData_i;
        if (!pop_tag.is_data) wgt_ch_q <= pop_tag.ch[CH_W-1:0];
      end
    end
  end

`ifdef FULLCONNECT_RDM_STALLCNT_EN
  logic [31:0] stall_cnt_q;

  // Stall counter: waitrequest cycles plus ISSUE cycles blocked by the outstanding limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (state_q == ST_IDLE && Start_i) begin
      stall_cnt_q <= '0;
    end else if (((rd_en && AvalonWaitReq_i) ||
                  (state_q == ST_ISSUE && pending_q == PEND_MAX)) &&
                 (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // Flag a readdatavalid that has no outstanding read to match.
  always_ff @(posedge clk) begin
    if (rstn && AvalonReadDataValid_i) begin
      assert (!fifo_empty) else $error("readdatavalid with no outstanding read");
    end
  end
`endif

  // full is implied by the pending limit; the tag channel may be wider than CH_W.
  logic unused_sigs;
  assign unused_sigs = ^{fifo_full, pop_tag.ch};

  assign AvalonAddr_o       = (slot_q == '0) ? data_base_q + ADDR_WIDTH'(idx_q)
                                             : chan_base_q + ADDR_WIDTH'(idx_q);
  assign AvalonRead_o       = rd_en;
  assign AvalonLock_o       = rd_en;
  assign AvalonByteEnable_o = '1;
  assign DataValid_o        = data_valid_q;
  assign WgtValid_o         = wgt_valid_q;
  assign WgtCh_o            = wgt_ch_q;
  assign Rd_o               = rd_q;
  assign Busy_o             = (state_q != ST_IDLE);
  assign Done_o             = (state_q == ST_DONE);

endmodule

// File: tb/tb_fullconnect_burst_read_master.sv
// Self-checking bench for fullconnect_burst_read_master: an Avalon slave model
// with programmable latency and waitrequest, plus address/response scoreboards.
module tb_fullconnect_burst_read_master;

  localparam int AW     = 32;
  localparam int DW     = 64;
  localparam int LW     = 9;
  localparam int NW     = 2;
  localparam int MP     = 8;
  localparam int CHW    = 1;
  localparam int WAIT_N = 5;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            Start_i = 1'b0;
  logic [LW-1:0]   Len_i = '0;
  logic [AW-1:0]   DataBase_i = '0;
  logic [AW-1:0]   WgtBase_i = '0;
  logic [AW-1:0]   WgtStride_i = '0;
  logic [AW-1:0]   AvalonAddr_o;
  logic            AvalonRead_o;
  logic            AvalonLock_o;
  logic [DW/8-1:0] AvalonByteEnable_o;
  logic            AvalonWaitReq_i = 1'b0;
  logic [DW-1:0]   AvalonReadData_i = '0;
  logic            AvalonReadDataValid_i = 1'b0;
  logic            DataValid_o;
  logic            WgtValid_o;
  logic [CHW-1:0]  WgtCh_o;
  logic [DW-1:0]   Rd_o;
  logic            Busy_o;
  logic            Done_o;
`ifdef FULLCONNECT_RDM_STALLCNT_EN
  logic [31:0]     StallCnt_o;
`endif

  always #5 clk = ~clk;

  fullconnect_burst_read_master #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .LEN_WIDTH   (LW),
    .NUM_WGT     (NW),
    .MAX_PENDING (MP)
  ) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .Start_i               (Start_i),
    .Len_i                 (Len_i),
    .DataBase_i            (DataBase_i),
    .WgtBase_i             (WgtBase_i),
    .WgtStride_i           (WgtStride_i),
    .AvalonAddr_o          (AvalonAddr_o),
    .AvalonRead_o          (AvalonRead_o),
    .AvalonLock_o          (AvalonLock_o),
    .AvalonByteEnable_o    (AvalonByteEnable_o),
    .AvalonWaitReq_i       (AvalonWaitReq_i),
    .AvalonReadData_i      (AvalonReadData_i),
    .AvalonReadDataValid_i (AvalonReadDataValid_i),
    .DataValid_o           (DataValid_o),
    .WgtValid_o            (WgtValid_o),
    .WgtCh_o               (WgtCh_o),
    .Rd_o                  (Rd_o),
    .Busy_o                (Busy_o),
`ifdef FULLCONNECT_RDM_STALLCNT_EN
    .StallCnt_o            (StallCnt_o),
`endif
    .Done_o                (Done_o)
  );

  typedef struct {
    logic          is_data;
    int            ch;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } rsp_t;

  int checks = 0;
  int failures = 0;

  exp_t          exp_out_q[$];
  logic [AW-1:0] exp_addr_q[$];
  rsp_t          resp_q[$];

  int            cyc = 0;
  int            lat = 2;
  int            n_accept, n_out, n_done, n_waited;
  int            outstanding, max_out;
  int            first_acc, last_acc, last_valid_cyc, done_cyc;
  bit            wait_armed = 1'b0;
  int            wait_left = 0;
  logic [AW-1:0] wait_addr = '0;
  exp_t          mon_e;
  rsp_t          mon_r;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Avalon slave model and output monitor, evaluated on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rstn) begin
      resp_q.delete();
      AvalonReadDataValid_i = 1'b0;
      AvalonWaitReq_i = 1'b0;
      outstanding = 0;
      wait_left = 0;
    end else begin
      if (DataValid_o || WgtValid_o) begin
        n_out++;
        last_valid_cyc = cyc;
        if (exp_out_q.size() == 0) begin
          check("out_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = exp_out_q.pop_front();
          check("out_data_valid", DataValid_o, mon_e.is_data);
          check("out_wgt_valid", WgtValid_o, !mon_e.is_data);
          if (!mon_e.is_data) check("out_ch", WgtCh_o, mon_e.ch);
          check("out_rd", Rd_o, mem_word(mon_e.addr));
        end
      end
      if (Done_o) begin
        n_done++;
        done_cyc = cyc;
      end
      if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
        mon_r = resp_q.pop_front();
        AvalonReadDataValid_i = 1'b1;
        AvalonReadData_i = mem_word(mon_r.addr);
        outstanding--;
      end else begin
        AvalonReadDataValid_i = 1'b0;
        AvalonReadData_i = '0;
      end
      AvalonWaitReq_i = 1'b0;
      if (AvalonRead_o && wait_left > 0) begin
        check("wait_addr_hold", AvalonAddr_o, wait_addr);
        AvalonWaitReq_i = 1'b1;
        wait_left--;
        n_waited++;
      end else if (AvalonRead_o && wait_armed && AvalonAddr_o == wait_addr) begin
        wait_armed = 1'b0;
        wait_left = WAIT_N - 1;
        AvalonWaitReq_i = 1'b1;
        n_waited++;
      end
      if (AvalonRead_o && !AvalonWaitReq_i) begin
        n_accept++;
        if (n_accept == 1) first_acc = cyc;
        last_acc = cyc;
        check("lock_follows_read", AvalonLock_o, 64'd1);
        if (exp_addr_q.size() == 0) check("accept_unexpected", 64'd1, 64'd0);
        else check("accept_addr", AvalonAddr_o, exp_addr_q.pop_front());
        resp_q.push_back('{due: cyc + lat, addr: AvalonAddr_o});
        outstanding++;
        if (outstanding > max_out) max_out = outstanding;
        check("outstanding_limit", outstanding <= MP, 64'd1);
      end
    end
  end

  task automatic start_run(input int len, input logic [AW-1:0] db,
                           input logic [AW-1:0] wb, input logic [AW-1:0] st);
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(db + AW'(i));
      exp_out_q.push_back('{is_data: 1'b1, ch: 0, addr: db + AW'(i)});
      for (int c = 0; c < NW; c++) begin
        exp_addr_q.push_back(wb + AW'(c) * st + AW'(i));
        exp_out_q.push_back('{is_data: 1'b0, ch: c, addr: wb + AW'(c) * st + AW'(i)});
      end
    end
    n_accept = 0; n_out = 0; n_done = 0; n_waited = 0; max_out = 0;
    @(negedge clk);
    Start_i = 1'b1;
    Len_i = LW'(len);
    DataBase_i = db;
    WgtBase_i = wb;
    WgtStride_i = st;
    @(negedge clk);
    Start_i = 1'b0;
    check("first_read", AvalonRead_o, 64'd1);
    check("busy_running", Busy_o, 64'd1);
  endtask

  task automatic finish_run(input int exp_outs);
    for (int k = 0; k < 3000 && n_done == 0; k++) @(negedge clk);
    check("done_seen", n_done != 0, 64'd1);
    repeat (3) @(negedge clk);
    check("done_once", n_done, 64'd1);
    check("out_count", n_out, exp_outs);
    check("exp_out_left", exp_out_q.size(), 64'd0);
    check("exp_addr_left", exp_addr_q.size(), 64'd0);
    if (exp_outs > 0) check("done_latency", done_cyc - last_valid_cyc, 64'd1);
    check("busy_after_done", Busy_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_read", AvalonRead_o, 64'd0);
    check("rst_lock", AvalonLock_o, 64'd0);
    check("rst_addr", AvalonAddr_o, 64'd0);
    check("rst_byteenable", AvalonByteEnable_o, 64'hFF);
    check("rst_outputs", {DataValid_o, WgtValid_o, WgtCh_o, Busy_o, Done_o}, 64'd0);
    check("rst_rd", Rd_o, 64'd0);
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run: Len=3, latency 2, back-to-back issue
    lat = 2;
    start_run(3, 32'h0000_1000, 32'h0000_8000, 32'h0000_0100);
    finish_run(3 * (NW + 1));
    check("throughput", last_acc - first_acc + 1, 3 * (NW + 1));

    // Waitrequest held 5 cycles on slot 2 of index 0
    wait_armed = 1'b1;
    wait_addr = 32'h0000_8000 + 32'h0000_0040;
    start_run(3, 32'h0000_3000, 32'h0000_8000, 32'h0000_0040);
    finish_run(3 * (NW + 1));
    check("wait_cycles", n_waited, WAIT_N);
`ifdef FULLCONNECT_RDM_STALLCNT_EN
    check("stall_cnt", StallCnt_o, 64'd5);
`endif

    // Outstanding limit with long latency; a start while busy must be ignored
    lat = 20;
    start_run(4, 32'hFFFF_FFFE, 32'h0001_0000, 32'h0000_0200);
    repeat (3) @(negedge clk);
    Start_i = 1'b1;
    Len_i = LW'(5);
    DataBase_i = 32'h0000_5555;
    @(negedge clk);
    Start_i = 1'b0;
    finish_run(4 * (NW + 1));
    check("max_outstanding", max_out, MP);

    // Zero length: no reads, Done in the cycle after start is taken
    lat = 2;
    n_accept = 0; n_done = 0;
    @(negedge clk);
    Start_i = 1'b1;
    Len_i = '0;
    @(negedge clk);
    Start_i = 1'b0;
    check("zero_done", Done_o, 64'd1);
    check("zero_read", AvalonRead_o, 64'd0);
    @(negedge clk);
    check("zero_done_end", Done_o, 64'd0);
    check("zero_busy_end", Busy_o, 64'd0);
    check("zero_accepts", n_accept, 64'd0);

    // Reset mid-run after 4 accepts, then a fresh run
    start_run(3, 32'h0000_2000, 32'h0000_9000, 32'h0000_0080);
    for (int k = 0; k < 200 && n_accept < 4; k++) @(negedge clk);
    check("reset_accepts_reached", n_accept >= 4, 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("midrst_read", AvalonRead_o, 64'd0);
    check("midrst_outputs", {DataValid_o, WgtValid_o, WgtCh_o, Busy_o, Done_o}, 64'd0);
    check("midrst_rd", Rd_o, 64'd0);
    check("midrst_byteenable", AvalonByteEnable_o, 64'hFF);
    repeat (2) @(negedge clk);
    exp_out_q.delete();
    exp_addr_q.delete();
    #2 rstn = 1'b1;
    start_run(2, 32'h0000_4000, 32'h0000_A000, 32'h0000_0010);
    finish_run(2 * (NW + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
